dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter LAT, default 3, access latency in cycles; legal range 1..15.
REQ-002 SHALL have parameter AW, default 8, word-index width; array depth is 2**AW 32-bit words.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port MEM, input, 2 bits: bit0 = load request, bit1 = store request; 00 = no request.
REQ-006 SHALL have port Addr, input, 32 bits: byte address of the access.
REQ-007 SHALL have port Wdata, input, 32 bits: store data.
REQ-008 SHALL have port Rdata, output, 32 bits: load result.
REQ-009 SHALL have port BUSY, output, 1 bit: requester must hold MEM/Addr/Wdata stable and stall while high.
REQ-010 SHALL have port RVALID, output, 1 bit: one-cycle completion pulse for load or store.

Function
REQ-011 SHALL implement states IDLE, ACCESS, DONE.
REQ-012 In IDLE with MEM != 00, SHALL go to ACCESS and load a 4-bit counter with LAT-1; with MEM = 00, SHALL stay in IDLE.
REQ-013 In ACCESS, SHALL decrement the counter each cycle while MEM != 00; at counter 0, SHALL perform the access and go to DONE.
REQ-014 In DONE, SHALL drive RVALID = 1 and BUSY = 0, then return to IDLE unconditionally after one cycle.
REQ-015 BUSY SHALL be combinational: 1 when (IDLE and MEM != 00) or ACCESS; otherwise 0.
REQ-016 Each request SHALL see BUSY high for LAT+1 cycles, then exactly one DONE cycle; the requester advances on the DONE edge.
REQ-017 The array word index SHALL be Addr[AW+1:2]; Addr[1:0] and Addr[31:AW+2] SHALL be ignored, so addresses wrap modulo the depth.
REQ-018 A load SHALL register array[index] into Rdata on the ACCESS-to-DONE edge; Rdata SHALL hold that value until the next load completes.
REQ-019 A store SHALL write Wdata to array[index] on the ACCESS-to-DONE edge and SHALL leave Rdata unchanged.
REQ-020 MEM = 11 SHALL be treated as a store only.
REQ-021 If MEM drops to 00 during ACCESS, SHALL abort: return to IDLE, no array write, no Rdata update, no RVALID.
REQ-022 A new request present in the cycle after DONE SHALL start normally from IDLE; back-to-back throughput is one access per LAT+2 cycles.
REQ-023 Addr, Wdata and MEM changes during ACCESS are a protocol violation; the values sampled on the completing edge SHALL be used.

Reset
REQ-024 On rst high, asynchronously and regardless of state, SHALL set state IDLE, counter 0, Rdata 0, RVALID 0.
REQ-025 While rst is high, BUSY SHALL be 0.
REQ-026 Reset mid-access SHALL discard the in-flight request with no array write.
REQ-027 Array contents SHALL NOT be reset.

Structure
REQ-028 The state encoding, MEM bit positions (LOAD = 0, STORE = 1) and the LAT range limit SHALL live in the shared pipeline package.
REQ-029 Storage SHALL be one sub-module, dmem_array: a single-port synchronous RAM with a 32-bit word, parameter AW, and inputs we, idx, wd, rd.
REQ-030 The FSM, counter and Rdata register SHALL reside in dmem_responder.

Verification
REQ-031 Reset, then store MEM = 10, Addr = 0x10, Wdata = 0xDEADBEEF with LAT = 3 -> BUSY high 4 cycles, RVALID in cycle 5, Rdata stays 0.
REQ-032 Then load MEM = 01, Addr = 0x12 -> same timing; Rdata = 0xDEADBEEF on RVALID (misaligned bits ignored).
REQ-033 Store 0x1 to Addr = 0x0, then load Addr = 0x400 with AW = 8 -> Rdata = 0x1 (wrap).
REQ-034 Load issued, MEM forced to 00 after 2 ACCESS cycles -> IDLE next cycle, no RVALID, Rdata unchanged.
REQ-035 rst asserted mid-store to Addr = 0x20 -> BUSY 0 and Rdata 0 immediately; a later load of 0x20 returns its pre-store value.
REQ-036 MEM = 11, Wdata = 0x55 to Addr = 0x8, then load 0x8 -> Rdata = 0x55; Rdata unchanged after the 11 access.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// -----------------------------------------------------------------------------
// dmem_responder_pkg
// Shared definitions for the data-memory responder: FSM state encoding, bit
// positions of the MEM request vector, the legal access-latency range and the
// latency counter width.
// -----------------------------------------------------------------------------
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StDone   = 2'd2
    } dmem_state_e;

    // Bit positions within the 2-bit MEM request vector.
    localparam int unsigned MemLoadBit  = 0;
    localparam int unsigned MemStoreBit = 1;

    // Legal access latency range; the counter is 4 bits wide.
    localparam int unsigned LatMin = 1;
    localparam int unsigned LatMax = 15;
    localparam int unsigned CntW   = 4;

endpackage

// File: rtl/dmem_array.sv
// -----------------------------------------------------------------------------
// dmem_array
// Single-port word RAM, 2**AW x 32 bits. Writes are synchronous; the read
// port is combinational so the word at idx on the completing edge is used.
// Contents are never reset.
//
// Ports:
//   clk  - clock, writes on rising edge
//   we   - write enable
//   idx  - word index
//   wd   - write data
//   rd   - read data (word at idx)
// -----------------------------------------------------------------------------
module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter int unsigned AW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wd,
    output logic [31:0]   rd
);

    logic [31:0] r_mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[idx] <= wd;
        end
    end

    assign rd = r_mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Fixed-latency data-memory responder. A request on MEM starts an access that
// keeps BUSY high for LAT+1 cycles, then completes with a one-cycle RVALID
// pulse. Loads capture the addressed word into Rdata; stores write Wdata.
// Dropping MEM to 00 mid-access aborts it without side effects.
//
// Ports:
//   clk    - clock
//   rst    - asynchronous active-high reset
//   MEM    - request: bit0 load, bit1 store (11 acts as store)
//   Addr   - byte address; word index is Addr[AW+1:2]
//   Wdata  - store data
//   Rdata  - last completed load result
//   BUSY   - requester must stall and hold inputs while high
//   RVALID - one-cycle completion pulse
// -----------------------------------------------------------------------------
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned LAT = 3,
    parameter int unsigned AW  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  MEM,
    input  logic [31:0] Addr,
    input  logic [31:0] Wdata,
    output logic [31:0] Rdata,
    output logic        BUSY,
    output logic        RVALID
);

    if (LAT < LatMin || LAT > LatMax) begin : g_lat_check
        $error("dmem_responder: LAT out of range 1..15");
    end

    localparam logic [CntW-1:0] LatInit = CntW'(LAT - 1);

    dmem_state_e     r_state;
    logic [CntW-1:0] r_cnt;
    logic [31:0]     r_rdata;
    logic            r_rvalid;

    logic            w_req;
    logic            w_complete;
    logic            w_we;
    logic [AW-1:0]   w_idx;
    logic [31:0]     w_rd;
    logic            w_unused_addr;

    assign w_req      = (MEM != 2'b00);
    assign w_complete = (r_state == StAccess) && w_req && (r_cnt == '0);
    assign w_we       = w_complete && MEM[MemStoreBit];
    assign w_idx      = Addr[AW+1:2];

    // Byte-offset and high address bits are deliberately ignored (wrap).
    assign w_unused_addr = ^{Addr[31:AW+2], Addr[1:0]};

    dmem_array #(
        .AW (AW)
    ) u_array (
        .clk (clk),
        .we  (w_we),
        .idx (w_idx),
        .wd  (Wdata),
        .rd  (w_rd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_req) begin
                        r_state <= StAccess;
                        r_cnt   <= LatInit;
                    end
                end
                StAccess: begin
                    if (!w_req) begin
                        // Requester withdrew: abort with no write or Rdata update.
                        r_state <= StIdle;
                        r_cnt   <= '0;
                    end else if (r_cnt == '0) begin
                        r_state  <= StDone;
                        r_rvalid <= 1'b1;
                        if (!MEM[MemStoreBit]) begin
                            r_rdata <= w_rd;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    // Combinational so the requester stalls in the same cycle it asks.
    assign BUSY   = !rst && (((r_state == StIdle) && w_req) || (r_state == StAccess));
    assign Rdata  = r_rdata;
    assign RVALID = r_rvalid;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    localparam int unsigned LAT   = 3;
    localparam int unsigned AW    = 8;
    localparam int unsigned Depth = 2 ** AW;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  MEM;
    logic [31:0] Addr;
    logic [31:0] Wdata;
    logic [31:0] Rdata;
    logic        BUSY;
    logic        RVALID;

    always #5 clk = ~clk;

    dmem_responder #(
        .LAT (LAT),
        .AW  (AW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .MEM    (MEM),
        .Addr   (Addr),
        .Wdata  (Wdata),
        .Rdata  (Rdata),
        .BUSY   (BUSY),
        .RVALID (RVALID)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference model: word memory, written flags, expected Rdata.
    logic [31:0] model_mem [Depth];
    bit          model_vld [Depth];
    logic [31:0] model_rdata;

    function automatic int unsigned idx_of(input logic [31:0] a);
        return (a / 4) % Depth;
    endfunction

    // Issue one request from a negedge, follow it to completion, check timing and data.
    task automatic do_req(input string name, input logic [1:0] m, input logic [31:0] a,
                          input logic [31:0] d);
        int          busy_cycles = 0;
        int          done_cycle  = -1;
        bit          held        = 1'b1;
        logic [31:0] old         = model_rdata;
        logic [31:0] exp_after;
        int unsigned k           = idx_of(a);
        exp_after = m[1] ? old : model_mem[k];
        MEM   = m;
        Addr  = a;
        Wdata = d;
        for (int c = 0; c < int'(LAT) + 8; c++) begin
            #1;
            if (RVALID) begin
                done_cycle = c;
                break;
            end
            if (BUSY) busy_cycles++;
            if (Rdata !== old) held = 1'b0;
            @(negedge clk);
        end
        total_cnt++;
        if (busy_cycles !== int'(LAT) + 1)
            $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_cycles, LAT + 1);
        else pass_cnt++;
        total_cnt++;
        if (done_cycle !== int'(LAT) + 1)
            $display("FAIL %s rvalid_cycle: got %0d expected %0d", name, done_cycle, LAT + 1);
        else pass_cnt++;
        total_cnt++;
        if (held !== 1'b1)
            $display("FAIL %s rdata_held_while_busy: got %0b expected 1", name, held);
        else pass_cnt++;
        total_cnt++;
        if (Rdata !== exp_after)
            $display("FAIL %s rdata_on_done: got %h expected %h", name, Rdata, exp_after);
        else pass_cnt++;
        if (m[1]) begin
            model_mem[k] = d;
            model_vld[k] = 1'b1;
        end else begin
            model_rdata = exp_after;
        end
        @(negedge clk);
        MEM = 2'b00;
        #1;
        total_cnt++;
        if (RVALID !== 1'b0 || Rdata !== model_rdata)
            $display("FAIL %s after_done: got rvalid=%0b rdata=%h expected rvalid=0 rdata=%h",
                     name, RVALID, Rdata, model_rdata);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        MEM   = 2'b00;
        Addr  = '0;
        Wdata = '0;
        model_rdata = '0;
        repeat (2) @(negedge clk);
        MEM = 2'b01;
        #1;
        total_cnt++;
        if (BUSY !== 1'b0 || RVALID !== 1'b0 || Rdata !== 32'h0)
            $display("FAIL reset_state: got busy=%0b rvalid=%0b rdata=%h expected 0 0 0",
                     BUSY, RVALID, Rdata);
        else pass_cnt++;
        MEM = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic_vectors();
        do_req("store_10", 2'b10, 32'h10, 32'hDEADBEEF);
        do_req("load_12", 2'b01, 32'h12, 32'h0);
        do_req("store_0", 2'b10, 32'h0, 32'h1);
        do_req("load_wrap_400", 2'b01, 32'h400, 32'h0);
        do_req("store11_8", 2'b11, 32'h8, 32'h55);
        do_req("load_8", 2'b01, 32'h8, 32'h0);
    endtask

    // Drop MEM after two ACCESS cycles; expect no completion and no side effects.
    task automatic abort_one(input string name, input logic [1:0] m, input logic [31:0] a,
                             input logic [31:0] d);
        logic [31:0] old = model_rdata;
        bit          saw_valid = 1'b0;
        bit          rd_bad    = 1'b0;
        logic        busy_after = 1'bx;
        MEM   = m;
        Addr  = a;
        Wdata = d;
        repeat (3) @(negedge clk);
        MEM = 2'b00;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (RVALID) saw_valid = 1'b1;
            if (Rdata !== old) rd_bad = 1'b1;
            if (c == 1) busy_after = BUSY;
            @(negedge clk);
        end
        total_cnt++;
        if (saw_valid !== 1'b0 || rd_bad !== 1'b0)
            $display("FAIL %s no_effect: got rvalid_seen=%0b rdata_changed=%0b expected 0 0",
                     name, saw_valid, rd_bad);
        else pass_cnt++;
        total_cnt++;
        if (busy_after !== 1'b0)
            $display("FAIL %s idle_after_abort: got busy=%0b expected 0", name, busy_after);
        else pass_cnt++;
    endtask

    task automatic test_abort();
        abort_one("abort_load", 2'b01, 32'h10, 32'h0);
        abort_one("abort_store", 2'b10, 32'h10, $urandom);
        do_req("load_after_abort", 2'b01, 32'h10, 32'h0);
    endtask

    task automatic test_reset_mid_store();
        do_req("store_20", 2'b10, 32'h20, 32'hA5A50F0F);
        do_req("load_20", 2'b01, 32'h20, 32'h0);
        MEM   = 2'b10;
        Addr  = 32'h20;
        Wdata = 32'h12345678;
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        total_cnt++;
        if (BUSY !== 1'b0 || Rdata !== 32'h0 || RVALID !== 1'b0)
            $display("FAIL reset_mid_store: got busy=%0b rdata=%h rvalid=%0b expected 0 0 0",
                     BUSY, Rdata, RVALID);
        else pass_cnt++;
        model_rdata = '0;
        @(negedge clk);
        MEM = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_req("load_20_after_reset", 2'b01, 32'h20, 32'h0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 60; i++) begin
            int unsigned op = $urandom_range(0, 2);
            logic [31:0] a  = $urandom;
            logic [31:0] d  = $urandom;
            logic [1:0]  m;
            m = (op == 0) ? 2'b01 : (op == 1) ? 2'b10 : 2'b11;
            if (m == 2'b01 && !model_vld[idx_of(a)]) m = 2'b10;
            // Re-issue immediately in the cycle after DONE.
            do_req($sformatf("b2b_%0d", i), m, a, d);
        end
    endtask

    initial begin
        for (int i = 0; i < int'(Depth); i++) begin
            model_vld[i] = 1'b0;
            model_mem[i] = '0;
        end
        test_reset();
        test_basic_vectors();
        test_abort();
        test_reset_mid_store();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
